// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op classification for the sequential ALU.
package alu_pkg;

   localparam int unsigned OP_W = 5;

   localparam logic [OP_W-1:0] OP_MOVE = 5'd0;
   localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
   localparam logic [OP_W-1:0] OP_AND  = 5'd3;
   localparam logic [OP_W-1:0] OP_OR   = 5'd4;
   localparam logic [OP_W-1:0] OP_NOT  = 5'd5;
   localparam logic [OP_W-1:0] OP_XOR  = 5'd6;
   localparam logic [OP_W-1:0] OP_EQ   = 5'd7;
   localparam logic [OP_W-1:0] OP_SLT  = 5'd8;
   localparam logic [OP_W-1:0] OP_SGT  = 5'd9;
   localparam logic [OP_W-1:0] OP_NLT  = 5'd10;
   localparam logic [OP_W-1:0] OP_NGT  = 5'd11;
   localparam logic [OP_W-1:0] OP_SLL  = 5'd12;
   localparam logic [OP_W-1:0] OP_SRL  = 5'd13;
   localparam logic [OP_W-1:0] OP_NE   = 5'd14;
   localparam logic [OP_W-1:0] OP_SLE  = 5'd15;
   localparam logic [OP_W-1:0] OP_SGE  = 5'd16;
   localparam logic [OP_W-1:0] OP_SRA  = 5'd17;
   localparam logic [OP_W-1:0] OP_MUL  = 5'd18;
   localparam logic [OP_W-1:0] OP_DIVU = 5'd19;
   localparam logic [OP_W-1:0] OP_REMU = 5'd20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_multicycle(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: unsigned shift-add multiply or restoring divide, one bit per cycle.
// The first step is taken on the start edge, so WIDTH steps finish WIDTH-1 cycles later.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic             mul_q;
   logic             busy_q;
   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    cnt_q;

   logic               mul_sel_c;
   logic [WIDTH-1:0]   d_sel_c;
   logic [WIDTH-1:0]   hi_sel_c;
   logic [WIDTH-1:0]   lo_sel_c;
   logic [2*WIDTH-1:0] nxt_c;

   // mul: {hi,lo} is {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
   function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] h,
                                               input logic [WIDTH-1:0] l,
                                               input logic [WIDTH-1:0] d,
                                               input logic             mul);
      logic [WIDTH:0]     t;
      logic [2*WIDTH-1:0] r;
      if (mul) begin
         t = {1'b0, h} + (l[0] ? {1'b0, d} : '0);
         r = {t, l[WIDTH-1:1]};
      end else begin
         t = {h, l[WIDTH-1]};
         if (t >= {1'b0, d}) r = {WIDTH'(t - {1'b0, d}), l[WIDTH-2:0], 1'b1};
         else                r = {t[WIDTH-1:0], l[WIDTH-2:0], 1'b0};
      end
      return r;
   endfunction

   // operand select: fresh inputs on start, held state otherwise
   always_comb begin
      mul_sel_c = mul_q;
      d_sel_c   = b_q;
      hi_sel_c  = hi;
      lo_sel_c  = lo;
      if (start) begin
         mul_sel_c = (op == OP_MUL);
         d_sel_c   = b;
         hi_sel_c  = '0;
         lo_sel_c  = a;
      end
      nxt_c = step(hi_sel_c, lo_sel_c, d_sel_c, mul_sel_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mul_q  <= 1'b0;
         busy_q <= 1'b0;
         b_q    <= '0;
         cnt_q  <= '0;
         done   <= 1'b0;
         lo     <= '0;
         hi     <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            {hi, lo} <= nxt_c;
            mul_q    <= (op == OP_MUL);
            b_q      <= b;
            cnt_q    <= CW'(WIDTH - 2);
            busy_q   <= 1'b1;
         end else if (busy_q) begin
            {hi, lo} <= nxt_c;
            if (cnt_q == '0) begin
               busy_q <= 1'b0;
               done   <= 1'b1;
            end else begin
               cnt_q <= cnt_q - CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake: single-cycle ops complete in one cycle,
// mul/divu/remu run on the iterative engine while the FSM stalls the requester.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SHW        = $clog2(WIDTH),
   parameter bit          SIGNED_CMP = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] alu_out_hi,
   output logic             zero,
   output logic             illegal_op,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [OP_W-1:0]  op_q;
   logic [WIDTH-1:0] lo_d, hi_d;
   logic             ill_d, dbz_d;
   logic             md_start_c;
   logic             md_done;
   logic [WIDTH-1:0] md_lo, md_hi;
   logic [WIDTH-1:0] single_c;
   logic             lt_c, gt_c;

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk   (clk),
      .reset (reset),
      .start (md_start_c),
      .op    (alu_op),
      .a     (operand_a),
      .b     (operand_b),
      .done  (md_done),
      .lo    (md_lo),
      .hi    (md_hi)
   );

   // single-cycle datapath
   always_comb begin
      lt_c     = operand_a < operand_b;
      gt_c     = operand_a > operand_b;
      single_c = '0;
      if (SIGNED_CMP) begin
         lt_c = $signed(operand_a) < $signed(operand_b);
         gt_c = $signed(operand_a) > $signed(operand_b);
      end
      case (alu_op)
         OP_MOVE: single_c = operand_a;
         OP_ADD:  single_c = operand_a + operand_b;
         OP_SUB:  single_c = operand_a - operand_b;
         OP_AND:  single_c = operand_a & operand_b;
         OP_OR:   single_c = operand_a | operand_b;
         OP_NOT:  single_c = ~operand_a;
         OP_XOR:  single_c = operand_a ^ operand_b;
         OP_EQ:   single_c = WIDTH'(operand_a == operand_b);
         OP_SLT:  single_c = WIDTH'(lt_c);
         OP_SGT:  single_c = WIDTH'(gt_c);
         OP_NLT:  single_c = WIDTH'(!lt_c);
         OP_NGT:  single_c = WIDTH'(!gt_c);
         OP_SLL:  single_c = operand_a << shamt;
         OP_SRL:  single_c = operand_a >> shamt;
         OP_NE:   single_c = WIDTH'(operand_a != operand_b);
         OP_SLE:  single_c = WIDTH'(!gt_c);
         OP_SGE:  single_c = WIDTH'(!lt_c);
         OP_SRA:  single_c = WIDTH'($signed(operand_a) >>> shamt);
         default: single_c = '0;
      endcase
   end

   // handshake FSM and result/flag next-state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lo_d       = alu_out;
      hi_d       = alu_out_hi;
      ill_d      = illegal_op;
      dbz_d      = div_by_zero;
      md_start_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = DONE;
               lo_d    = single_c;
               hi_d    = '0;
               ill_d   = 1'b0;
               dbz_d   = 1'b0;
               if (alu_op > OP_REMU) begin
                  ill_d = 1'b1;
                  lo_d  = '0;
               end else if (is_multicycle(alu_op)) begin
                  if (alu_op != OP_MUL && operand_b == '0) begin
                     dbz_d = 1'b1;
                     lo_d  = (alu_op == OP_DIVU) ? '1 : operand_a;
                     hi_d  = (alu_op == OP_DIVU) ? operand_a : '1;
                  end else begin
                     md_start_c = 1'b1;
                     cnt_d      = CW'(WIDTH - 1);
                     state_d    = BUSY;
                  end
               end
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               if (md_done) begin
                  state_d = DONE;
                  lo_d    = (op_q == OP_REMU) ? md_hi : md_lo;
                  hi_d    = (op_q == OP_REMU) ? md_lo : md_hi;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         alu_out     <= '0;
         alu_out_hi  <= '0;
         zero        <= 1'b1;
         illegal_op  <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         if (state_q == IDLE && in_valid) op_q <= alu_op;
         in_ready    <= (state_d == IDLE);
         out_valid   <= (state_d == DONE);
         alu_out     <= lo_d;
         alu_out_hi  <= hi_d;
         zero        <= (lo_d == '0);
         illegal_op  <= ill_d;
         div_by_zero <= dbz_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, stall/reset sequences,
// and random ops against an arithmetic reference model.
module tb_alu_seq;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [4:0]   alu_op, shamt;
   logic [W-1:0] operand_a, operand_b, alu_out, alu_out_hi;
   logic         zero, illegal_op, div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [4:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [4:0]   sh;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         ill;
      logic         dbz;
      int           lat;
   } vec_t;

   vec_t tbl [16];

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W), .SHW(5), .SIGNED_CMP(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_op      (alu_op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .shamt       (shamt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_out     (alu_out),
      .alu_out_hi  (alu_out_hi),
      .zero        (zero),
      .illegal_op  (illegal_op),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   // Reference: plain arithmetic on the op definitions (signed compares enabled)
   function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] sh, output logic [W-1:0] lo, output logic [W-1:0] hi,
                                 output logic ill, output logic dbz, output int lat);
      logic [63:0] p;
      lo = '0; hi = '0; ill = 1'b0; dbz = 1'b0; lat = 1;
      case (op)
         5'd0:  lo = a;
         5'd1:  lo = a + b;
         5'd2:  lo = a - b;
         5'd3:  lo = a & b;
         5'd4:  lo = a | b;
         5'd5:  lo = ~a;
         5'd6:  lo = a ^ b;
         5'd7:  lo = 32'(a == b);
         5'd8:  lo = 32'($signed(a) <  $signed(b));
         5'd9:  lo = 32'($signed(a) >  $signed(b));
         5'd10: lo = 32'($signed(a) >= $signed(b));
         5'd11: lo = 32'($signed(a) <= $signed(b));
         5'd12: lo = a << sh;
         5'd13: lo = a >> sh;
         5'd14: lo = 32'(a != b);
         5'd15: lo = 32'($signed(a) <= $signed(b));
         5'd16: lo = 32'($signed(a) >= $signed(b));
         5'd17: lo = 32'($signed(a) >>> sh);
         5'd18: begin
            p = 64'(a) * 64'(b);
            lo = p[31:0]; hi = p[63:32]; lat = W + 1;
         end
         5'd19, 5'd20: begin
            if (b == 0) begin
               lo = '1; hi = a; dbz = 1'b1;
            end else begin
               lo = a / b; hi = a % b; lat = W + 1;
            end
            if (op == 5'd20) {lo, hi} = {hi, lo};
         end
         default: ill = 1'b1;
      endcase
   endfunction

   // Issue one op from IDLE, wait for the result (bounded), optionally stall, then consume it
   task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh, input int stall,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic eill,
                         input logic edbz, input int elat);
      int lat;
      logic [W-1:0] lo, hi;
      in_valid = 1'b1; alu_op = op; operand_a = a; operand_b = b; shamt = sh;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      alu_op = 5'($urandom); operand_a = $urandom; operand_b = $urandom; shamt = 5'($urandom);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      lo = alu_out; hi = alu_out_hi;
      chk({tag, " latency"}, 64'(lat), 64'(elat));
      chk({tag, " alu_out"}, 64'(lo), 64'(elo));
      chk({tag, " alu_out_hi"}, 64'(hi), 64'(ehi));
      chk({tag, " zero"}, 64'(zero), 64'(elo == 0));
      chk({tag, " illegal_op"}, 64'(illegal_op), 64'(eill));
      chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
         chk({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
         chk({tag, " stall alu_out"}, 64'(alu_out), 64'(elo));
         chk({tag, " stall alu_out_hi"}, 64'(alu_out_hi), 64'(ehi));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, " drop out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, " back in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [4:0]   rop, rsh;
      logic [W-1:0] ra, rb, elo, ehi;
      logic         eill, edbz;
      int           elat, stale;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      alu_op = '0; operand_a = '0; operand_b = '0; shamt = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset alu_out", 64'(alu_out), 64'd0);
      chk("reset alu_out_hi", 64'(alu_out_hi), 64'd0);
      chk("reset zero", 64'(zero), 64'd1);
      chk("reset flags", 64'({illegal_op, div_by_zero}), 64'd0);

      tbl[0]  = '{5'd2,  32'd5,          32'd5,          5'd0, 32'd0,          32'd0,          1'b0, 1'b0, 1};
      tbl[1]  = '{5'd18, 32'hFFFF_FFFF,  32'd2,          5'd0, 32'hFFFF_FFFE,  32'd1,          1'b0, 1'b0, 33};
      tbl[2]  = '{5'd19, 32'd100,        32'd7,          5'd0, 32'd14,         32'd2,          1'b0, 1'b0, 33};
      tbl[3]  = '{5'd19, 32'd100,        32'd0,          5'd0, 32'hFFFF_FFFF,  32'd100,        1'b0, 1'b1, 1};
      tbl[4]  = '{5'd17, 32'h8000_0001,  32'd0,          5'd4, 32'hF800_0000,  32'd0,          1'b0, 1'b0, 1};
      tbl[5]  = '{5'd13, 32'h8000_0001,  32'd0,          5'd4, 32'h0800_0000,  32'd0,          1'b0, 1'b0, 1};
      tbl[6]  = '{5'd8,  32'hFFFF_FFFF,  32'd1,          5'd0, 32'd1,          32'd0,          1'b0, 1'b0, 1};
      tbl[7]  = '{5'd25, 32'd123,        32'd45,         5'd0, 32'd0,          32'd0,          1'b1, 1'b0, 1};
      tbl[8]  = '{5'd20, 32'd100,        32'd7,          5'd0, 32'd2,          32'd14,         1'b0, 1'b0, 33};
      tbl[9]  = '{5'd12, 32'h8000_0001,  32'd0,          5'd4, 32'h0000_0010,  32'd0,          1'b0, 1'b0, 1};
      tbl[10] = '{5'd12, 32'h8000_0001,  32'd0,          5'd0, 32'h8000_0001,  32'd0,          1'b0, 1'b0, 1};
      tbl[11] = '{5'd1,  32'hFFFF_FFFF,  32'd1,          5'd0, 32'd0,          32'd0,          1'b0, 1'b0, 1};
      tbl[12] = '{5'd5,  32'd0,          32'd9,          5'd0, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1};
      tbl[13] = '{5'd9,  32'd1,          32'hFFFF_FFFF,  5'd0, 32'd1,          32'd0,          1'b0, 1'b0, 1};
      tbl[14] = '{5'd20, 32'h37,         32'd0,          5'd0, 32'h37,         32'hFFFF_FFFF,  1'b0, 1'b1, 1};
      tbl[15] = '{5'd31, 32'd7,          32'd7,          5'd3, 32'd0,          32'd0,          1'b1, 1'b0, 1};

      for (int i = 0; i < 16; i++)
         run_op($sformatf("vec%0d op%0d", i, tbl[i].op), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, 0,
                tbl[i].lo, tbl[i].hi, tbl[i].ill, tbl[i].dbz, tbl[i].lat);

      // mul result must stay frozen while the consumer stalls
      run_op("mul stall", 5'd18, 32'hFFFF_FFFF, 32'd2, 5'd0, 3, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 33);

      // reset in the middle of a multiply abandons it
      in_valid = 1'b1; alu_op = 5'd18; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midreset out_valid", 64'(out_valid), 64'd0);
      chk("midreset in_ready", 64'(in_ready), 64'd1);
      chk("midreset alu_out", 64'(alu_out), 64'd0);
      stale = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      chk("midreset no stale result", 64'(stale), 64'd0);

      // random ops against the reference model
      for (int n = 0; n < 150; n++) begin
         rop = 5'($urandom_range(0, 23));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
         rsh = 5'($urandom);
         model(rop, ra, rb, rsh, elo, ehi, eill, edbz, elat);
         run_op($sformatf("rnd%0d op%0d", n, rop), rop, ra, rb, rsh, int'($urandom_range(0, 2)),
                elo, ehi, eill, edbz, elat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
